// File: rtl/cordic_vectoring_fixed.sv
// CORDIC vectoring engine: converts (x_in, y_in) into magnitude, residual y
// and angle, one micro-rotation per clock, followed by a gain-correction step.
module cordic_vectoring_fixed #(
    parameter int N              = 15,
    parameter int wordLength     = 16,
    parameter int fractionLength = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid,
    input  logic signed [wordLength-1:0] x_in,
    input  logic signed [wordLength-1:0] y_in,
    output logic                         ready,
    output logic signed [wordLength-1:0] x_out,
    output logic signed [wordLength-1:0] y_out,
    output logic signed [wordLength-1:0] z_out,
    output logic                         done
);
    localparam int W  = wordLength;
    localparam int XW = 2 * wordLength;   // internal x/y width, wide enough for the CORDIC gain
    localparam int PW = 4 * wordLength;   // gain-correction product width
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // atan(2^-i) with 30 fraction bits; past the table atan(2^-i) equals 2^-i at that precision
    function automatic longint atan_q30(input int i);
        case (i)
            0:       atan_q30 = 64'sd843314856;
            1:       atan_q30 = 64'sd497837829;
            2:       atan_q30 = 64'sd263043836;
            3:       atan_q30 = 64'sd133525158;
            4:       atan_q30 = 64'sd67021686;
            5:       atan_q30 = 64'sd33543515;
            6:       atan_q30 = 64'sd16775850;
            7:       atan_q30 = 64'sd8388437;
            8:       atan_q30 = 64'sd4194282;
            9:       atan_q30 = 64'sd2097149;
            10:      atan_q30 = 64'sd1048575;
            11:      atan_q30 = 64'sd524287;
            12:      atan_q30 = 64'sd262143;
            13:      atan_q30 = 64'sd131071;
            14:      atan_q30 = 64'sd65535;
            default: atan_q30 = (i <= 30) ? (64'sd1 <<< (30 - i)) : 64'sd0;
        endcase
    endfunction

    // Round a 30-fraction-bit constant to fractionLength fraction bits
    function automatic longint from_q30(input longint v);
        if (fractionLength >= 30)
            from_q30 = v <<< (fractionLength - 30);
        else
            from_q30 = (v + (64'sd1 <<< (29 - fractionLength))) >>> (30 - fractionLength);
    endfunction

    // Clamp a wide signed value to the signed W-bit range
    function automatic logic signed [W-1:0] sat_w(input logic signed [PW-1:0] v);
        if (v[PW-1:W-1] == {(PW-W+1){v[PW-1]}})
            sat_w = v[W-1:0];
        else if (v[PW-1])
            sat_w = {1'b1, {(W-1){1'b0}}};
        else
            sat_w = {1'b0, {(W-1){1'b1}}};
    endfunction

    localparam longint PI_Q30 = 64'sd3373259426;   // pi
    localparam longint K_Q30  = 64'sd652032837;    // 0.6072529, inverse CORDIC gain
    localparam longint PI_L   = from_q30(PI_Q30);
    localparam longint K_L    = from_q30(K_Q30);
    localparam logic signed [W-1:0]  PI_W      = PI_L[W-1:0];
    localparam logic signed [XW-1:0] K_X       = K_L[XW-1:0];
    localparam logic [IW-1:0]        LAST_ITER = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, ITER, SCALE} state_t;

    state_t               state_reg;
    logic signed [XW-1:0] x_reg, y_reg;
    logic signed [W-1:0]  z_reg;
    logic [IW-1:0]        iter_reg;
    logic                 zero_reg;
    logic                 ready_reg;
    logic                 done_reg;
    logic signed [W-1:0]  x_out_reg, y_out_reg, z_out_reg;

    logic signed [W-1:0]  atan_tab [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_atan
            localparam longint ATAN_L = from_q30(atan_q30(gi));
            assign atan_tab[gi] = ATAN_L[W-1:0];
        end
    endgenerate

    logic signed [XW-1:0] x_ext, y_ext;
    logic signed [XW-1:0] x_cap_next, y_cap_next;
    logic signed [W-1:0]  z_cap_next;
    logic                 zero_in;

    assign x_ext   = {{W{x_in[W-1]}}, x_in};
    assign y_ext   = {{W{y_in[W-1]}}, y_in};
    assign zero_in = (x_in == '0) && (y_in == '0);

    // Pre-rotation into the right half-plane so the micro-rotations converge
    always_comb begin
        x_cap_next = x_ext;
        y_cap_next = y_ext;
        z_cap_next = '0;
        if (x_in[W-1]) begin
            x_cap_next = -x_ext;
            y_cap_next = -y_ext;
            z_cap_next = y_in[W-1] ? -PI_W : PI_W;
        end
    end

    logic signed [XW-1:0] x_sh, y_sh, x_next, y_next;
    logic signed [W-1:0]  z_next, atan_cur;

    // One micro-rotation driving y toward zero; both updates use the old x and y
    always_comb begin
        x_sh     = x_reg >>> iter_reg;
        y_sh     = y_reg >>> iter_reg;
        atan_cur = atan_tab[iter_reg];
        if (!y_reg[XW-1]) begin
            x_next = x_reg + y_sh;
            y_next = y_reg - x_sh;
            z_next = z_reg + atan_cur;
        end else begin
            x_next = x_reg - y_sh;
            y_next = y_reg + x_sh;
            z_next = z_reg - atan_cur;
        end
    end

    logic signed [PW-1:0] prod, prod_sh, y_wide;

    assign prod    = {{(PW-XW){x_reg[XW-1]}}, x_reg} * {{(PW-XW){1'b0}}, K_X};
    assign prod_sh = prod >>> fractionLength;
    assign y_wide  = {{(PW-XW){y_reg[XW-1]}}, y_reg};

    // Control FSM and datapath registers: capture, iterate N times, then scale and publish
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            iter_reg  <= '0;
            zero_reg  <= 1'b0;
            ready_reg <= 1'b1;
            done_reg  <= 1'b0;
            x_out_reg <= '0;
            y_out_reg <= '0;
            z_out_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (valid && ready_reg) begin
                        x_reg     <= x_cap_next;
                        y_reg     <= y_cap_next;
                        z_reg     <= z_cap_next;
                        zero_reg  <= zero_in;
                        iter_reg  <= '0;
                        ready_reg <= 1'b0;
                        state_reg <= ITER;
                    end
                end
                ITER: begin
                    x_reg <= x_next;
                    y_reg <= y_next;
                    z_reg <= z_next;
                    if (iter_reg == LAST_ITER) begin
                        state_reg <= SCALE;
                    end else begin
                        iter_reg <= iter_reg + IW'(1);
                    end
                end
                SCALE: begin
                    if (zero_reg) begin
                        x_out_reg <= '0;
                        y_out_reg <= '0;
                        z_out_reg <= '0;
                    end else begin
                        x_out_reg <= sat_w(prod_sh);
                        y_out_reg <= sat_w(y_wide);
                        z_out_reg <= z_reg;
                    end
                    done_reg  <= 1'b1;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ready = ready_reg;
    assign done  = done_reg;
    assign x_out = x_out_reg;
    assign y_out = y_out_reg;
    assign z_out = z_out_reg;

endmodule

// File: doc/cordic_vectoring_fixed.md
CORDIC_VECTORING_FIXED -- requirements
Module: cordic_vectoring_fixed

Interface
REQ-001 SHALL have parameter N, default 15: number of CORDIC micro-rotations.
REQ-002 SHALL have parameter wordLength, default 16: I/O word width, signed two's complement.
REQ-003 SHALL have parameter fractionLength, default 12: fraction bits of x, y and angle (radians).
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port valid  input  1  request; inputs are captured when valid=1 and ready=1.
REQ-007 SHALL have port x_in  input  wordLength  signed x component.
REQ-008 SHALL have port y_in  input  wordLength  signed y component.
REQ-009 SHALL have port ready  output  1  high only in IDLE.
REQ-010 SHALL have port x_out  output  wordLength  gain-compensated magnitude sqrt(x^2+y^2).
REQ-011 SHALL have port y_out  output  wordLength  residual y (about 0).
REQ-012 SHALL have port z_out  output  wordLength  angle atan2(y_in,x_in), range [-pi, pi].
REQ-013 SHALL have port done  output  1  one-cycle pulse when outputs update.

Function
REQ-014 SHALL implement states IDLE, ITER and SCALE; IDLE->ITER on capture, ITER->SCALE after iteration N-1, SCALE->IDLE unconditionally.
REQ-015 SHALL apply pre-rotation at the capture edge: if x_in<0 then x=-x_in, y=-y_in, z=+PI when y_in>=0, else z=-PI; otherwise x=x_in, y=y_in, z=0.
REQ-016 SHALL have PI = round(pi*2^fractionLength), 12868 at the defaults.
REQ-017 SHALL hold x and y internally as 2*wordLength-bit signed values, sign-extended from the inputs, with no overflow possible.
REQ-018 SHALL perform, at iteration i (0..N-1) with y>=0: x+=y>>>i, y-=x>>>i, z+=ATAN[i]; with y<0: x-=y>>>i, y+=x>>>i, z-=ATAN[i]. Both updates use the previous-cycle x and y.
REQ-019 SHALL have ATAN[i] = round(atan(2^-i)*2^fractionLength), a constant table; ATAN[0]=3217 at the defaults.
REQ-020 SHALL, in SCALE, compute x_out = sat_wordLength((x*K)>>>fractionLength) with K = round(0.6072529*2^fractionLength), 2487 at the defaults.
REQ-021 SHALL, in SCALE, set y_out = sat_wordLength(y) and z_out = z.
REQ-022 SHALL saturate to the signed wordLength limits 0x7FFF/0x8000 at the defaults.
REQ-023 SHALL register x_out, y_out and z_out at the SCALE edge and set done=1 at that same edge.
REQ-024 SHALL clear done at the next edge, so that done is high for exactly one cycle.
REQ-025 SHALL capture at edge E0 and make done and the outputs visible after edge E(N+1), a latency of N+1 cycles.
REQ-026 SHALL hold x_out, y_out and z_out stable between done pulses.
REQ-027 SHALL ignore valid while ready=0; no queuing and no effect on the operation in flight.
REQ-028 SHALL accept a new capture in the cycle in which done is high (state IDLE), for back-to-back throughput of one result per N+2 cycles.
REQ-029 SHALL produce x_out=0, y_out=0 and z_out=0 when x_in=0 and y_in=0; the flag is latched at capture and overrides SCALE.
REQ-030 SHALL, when x_in=0 and y_in!=0, produce z = +/-pi/2 through normal iteration; no special case.

Reset
REQ-031 SHALL, when rst=1 at a rising edge, set the state to IDLE, set x_out, y_out, z_out, done and the internal registers to 0, and set ready=1.
REQ-032 SHALL, when rst is asserted mid-operation, abort the operation with no done pulse; rst has priority over valid.

Verification
REQ-033 SHALL check x_in=0x1000, y_in=0x0000 -> x_out=0x1000+/-4 LSB, z_out=0x0000+/-4, done exactly N+1 cycles after capture.
REQ-034 SHALL check x_in=0x1000, y_in=0x1000 -> x_out=0x16A1+/-4, z_out=0x0C91+/-4, y_out=0+/-4.
REQ-035 SHALL check x_in=0xF000, y_in=0x0000 -> x_out=0x1000+/-4, z_out=0x3244+/-4 (+pi); with y_in=0xFFFF, z_out near 0xCDBC (-pi).
REQ-036 SHALL check x_in=0x0000, y_in=0xE000 -> x_out=0x2000+/-4, z_out=0xE6DE+/-4 (-pi/2).
REQ-037 SHALL check x_in=y_in=0 -> all outputs 0x0000 with one done pulse; valid pulsed during ITER -> ignored, single done.
REQ-038 SHALL check rst asserted at iteration 5 -> no done, outputs 0, ready=1 next cycle; a following request completes with correct results and latency.
